// File: rtl/ann_out_layer_argmax_pkg.sv
// Shared constants and types for the output-layer argmax stage and its MAC.
// The same MAC and types are reused by the hidden-layer stage.
package ann_pkg;
    localparam int N_IN   = 50;
    localparam int N_OUT  = 10;
    localparam int AW     = 6;
    localparam int DW     = 9;
    localparam int WW     = 9;
    localparam int WAW    = 9;
    localparam int ACC_W  = 24;
    // unsigned activation gets one extra sign bit before the signed multiply
    localparam int PROD_W = DW + 1 + WW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef logic signed [ACC_W-1:0] score_t;
    typedef logic [3:0] digit_t;
endpackage

// File: rtl/ann_out_layer_argmax_if.sv
// Control, activation-buffer read port, weight-ROM port and result bundle.
// The slave modport is the argmax stage; the master is its surroundings.
interface ann_out_layer_argmax_if import ann_pkg::*; ();
    logic                 start;
    logic [AW-1:0]        act_addr;
    logic [DW-1:0]        act_data;
    logic [WAW-1:0]       w_addr;
    logic signed [WW-1:0] w_data;
    logic                 busy;
    logic                 done;
    digit_t               digit;
    score_t               score;

    modport slave (
        input  start, act_data, w_data,
        output act_addr, w_addr, busy, done, digit, score
    );

    modport master (
        output start, act_data, w_data,
        input  act_addr, w_addr, busy, done, digit, score
    );
endinterface

// File: rtl/ann_out_layer_argmax_mac.sv
// Sequential multiply-accumulate: unsigned activation times signed weight.
// 'first' loads the product so each neuron starts without a separate clear.
module ann_mac import ann_pkg::*; (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 first,
    input  logic [DW-1:0]        a,
    input  logic signed [WW-1:0] w,
    output score_t               acc
);
    logic signed [PROD_W-1:0] w_a_ext;
    logic signed [PROD_W-1:0] w_w_ext;
    logic signed [PROD_W-1:0] w_prod;
    score_t                   w_prod_ext;
    score_t                   r_acc;

    assign w_a_ext    = {{(PROD_W-DW){1'b0}}, a};
    assign w_w_ext    = {{(PROD_W-WW){w[WW-1]}}, w};
    assign w_prod     = w_a_ext * w_w_ext;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= first ? w_prod_ext : r_acc + w_prod_ext;
        end
    end

    assign acc = r_acc;
endmodule

// File: rtl/ann_out_layer_argmax.sv
// Output layer: streams 50 activations x 10 neurons through one MAC and
// reports the index and score of the largest dot product (ties -> lowest index).
module ann_out_layer_argmax import ann_pkg::*; (
    input  logic                  clk,
    input  logic                  rst,
    ann_out_layer_argmax_if.slave bus
);
    localparam int N_TOT = N_IN * N_OUT;

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_i;
    digit_t        r_n;
    logic [WAW-1:0] r_w_addr;
    logic          r_drain;
    logic          r_v1, r_first1, r_last1;
    digit_t        r_n1;
    logic          r_cmp2;
    digit_t        r_n2;
    score_t        w_acc, w_best, r_max, r_score;
    digit_t        w_best_idx, r_max_idx, r_digit;
    logic          w_accept, w_last_issue, w_take;

    assign w_accept     = (r_state == IDLE) && bus.start;
    assign w_last_issue = (r_state == RUN) && (r_w_addr == WAW'(N_TOT - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start)   w_state_next = RUN;
            RUN:     if (w_last_issue) w_state_next = DRAIN;
            DRAIN:   if (r_drain)     w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Address counters hold their last values outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i      <= '0;
            r_n      <= '0;
            r_w_addr <= '0;
            r_drain  <= 1'b0;
        end else begin
            r_drain <= (r_state == DRAIN) && !r_drain;
            if (w_accept) begin
                r_i      <= '0;
                r_n      <= '0;
                r_w_addr <= '0;
            end else if ((r_state == RUN) && !w_last_issue) begin
                r_w_addr <= r_w_addr + 1'b1;
                if (r_i == AW'(N_IN - 1)) begin
                    r_i <= '0;
                    r_n <= r_n + 1'b1;
                end else begin
                    r_i <= r_i + 1'b1;
                end
            end
        end
    end

    // Tags follow the 1-cycle memory latency, then one more stage to the compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_first1 <= 1'b0;
            r_last1  <= 1'b0;
            r_n1     <= '0;
            r_cmp2   <= 1'b0;
            r_n2     <= '0;
        end else begin
            r_v1     <= (r_state == RUN);
            r_first1 <= (r_i == '0);
            r_last1  <= (r_i == AW'(N_IN - 1));
            r_n1     <= r_n;
            r_cmp2   <= r_v1 && r_last1;
            r_n2     <= r_n1;
        end
    end

    ann_mac u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (r_v1),
        .first (r_first1),
        .a     (bus.act_data),
        .w     (bus.w_data),
        .acc   (w_acc)
    );

    assign w_take     = (r_n2 == '0) || (w_acc > r_max);
    assign w_best     = w_take ? w_acc : r_max;
    assign w_best_idx = w_take ? r_n2 : r_max_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max     <= '0;
            r_max_idx <= '0;
            r_digit   <= '0;
            r_score   <= '0;
        end else if (r_cmp2) begin
            r_max     <= w_best;
            r_max_idx <= w_best_idx;
            if (r_n2 == digit_t'(N_OUT - 1)) begin
                r_digit <= w_best_idx;
                r_score <= w_best;
            end
        end
    end

    assign bus.act_addr = r_i;
    assign bus.w_addr   = r_w_addr;
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);
    assign bus.digit    = r_digit;
    assign bus.score    = r_score;
endmodule
